// File: rtl/banner_pkg.sv
// banner_pkg: shared palette, animation modes and banner bitmap for banner_src
package banner_pkg;
   typedef enum logic [1:0] {MODE_STATIC, MODE_CYCLE, MODE_BLINK, MODE_SCROLL} mode_t;
   localparam logic [11:0] PALETTE [0:7] = '{12'hf00, 12'hf8b, 12'hfa0, 12'h00b,
                                             12'h0bb, 12'hee0, 12'ha2c, 12'h777};
   function automatic logic bitmap_bit(input int unsigned a, input int hb);
      return (a & 7) == 0 || ((a >> hb) & 7) == 3;
   endfunction
endpackage

// File: rtl/banner_rom.sv
// banner_rom: synchronous 1-bit banner bitmap ROM, row-major {row, col} addressing
module banner_rom
   import banner_pkg::*;
#(
   parameter int ADDR = 15,
   parameter int H_BITS = 9
) (
   input  logic            clk,
   input  logic [ADDR-1:0] addr,
   output logic            data
);
   // registered read of the bitmap pixel
   always_ff @(posedge clk)
      data <= bitmap_bit(32'(addr), H_BITS);
endmodule

// File: rtl/banner_src.sv
// banner_src: animated, optionally scrolled and 2x-scaled banner sprite source
module banner_src
   import banner_pkg::*;
#(
   parameter int CD = 12,
   parameter int H_SIZE = 512,
   parameter int V_SIZE = 64,
   parameter int ADDR = 15,
   parameter logic [CD-1:0] KEY_COLOR = 0,
   parameter logic [CD-1:0] BG_COLOR = 12'h000
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [10:0]   x,
   input  logic [10:0]   y,
   input  logic [10:0]   x0,
   input  logic [10:0]   y0,
   input  logic [1:0]    mode,
   input  logic [5:0]    period,
   input  logic          scale,
   output logic [CD-1:0] sprite_rgb,
   output logic [2:0]    ani_id
);
   localparam int HB = $clog2(H_SIZE);
   localparam int VB = $clog2(V_SIZE);
   mode_t md;
   logic [10:0] x_d1;
   logic [5:0] c;
   logic [HB-1:0] scroll_off, xs;
   logic frame_tick, step_tick, in_region, blank, rom_bit, v1, in1, blank1;
   logic signed [11:0] xr, yr, xe, ye;
   logic [ADDR-1:0] addr;
   logic [CD-1:0] fg, fg1;
   assign md = mode_t'(mode);
   // frame timing, sprite-relative coordinates, ROM address and foreground colour
   always_comb begin
      frame_tick = x_d1 == 11'd0 && x == 11'd1 && y == 11'd0;
      step_tick = frame_tick && c == 6'd0;
      xr = $signed({1'b0, x}) - $signed({1'b0, x0});
      yr = $signed({1'b0, y}) - $signed({1'b0, y0});
      xe = scale ? xr >>> 1 : xr;
      ye = scale ? yr >>> 1 : yr;
      in_region = !xr[11] && !yr[11] && xe < 12'(H_SIZE) && ye < 12'(V_SIZE);
      xs = xe[HB-1:0] + scroll_off;
      addr = {ye[VB-1:0], xs};
      fg = CD'(PALETTE[(md == MODE_CYCLE || md == MODE_SCROLL) ? ani_id : 3'd0]);
      blank = md == MODE_BLINK && ani_id[0];
   end
   banner_rom #(.ADDR(ADDR), .H_BITS(HB)) u_rom (
      .clk(clk),
      .addr(addr),
      .data(rom_bit)
   );
   // previous x, frame counter and animation step
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         x_d1 <= '0;
         c <= '0;
         ani_id <= '0;
      end else begin
         x_d1 <= x;
         if (frame_tick) c <= (c >= period) ? 6'd0 : c + 6'd1;
         if (step_tick) ani_id <= ani_id + 3'd1;
      end
   // horizontal scroll offset, live only in scroll mode
   always_ff @(posedge clk or posedge reset)
      if (reset) scroll_off <= '0;
      else scroll_off <= (md != MODE_SCROLL) ? '0 : frame_tick ? scroll_off + HB'(1) : scroll_off;
   // stage 1: attributes travel alongside the ROM read so they line up with its data
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         v1 <= 1'b0;
         in1 <= 1'b0;
         fg1 <= '0;
         blank1 <= 1'b0;
      end else begin
         v1 <= 1'b1;
         in1 <= in_region;
         fg1 <= fg;
         blank1 <= blank;
      end
   // stage 2: final colour select
   always_ff @(posedge clk or posedge reset)
      if (reset) sprite_rgb <= KEY_COLOR;
      else sprite_rgb <= (!v1 || !in1 || blank1) ? KEY_COLOR : rom_bit ? BG_COLOR : fg1;
endmodule

// File: tb/tb_banner_src.sv
// tb_banner_src: directed stimulus with a per-cycle reference model and literal spot checks
module tb_banner_src;
   localparam int H = 512;
   localparam int V = 64;
   localparam logic [11:0] KEY = 12'h0f0;
   localparam logic [11:0] BG = 12'h123;
   localparam logic [11:0] PAL [0:7] = '{12'hf00, 12'hf8b, 12'hfa0, 12'h00b,
                                         12'h0bb, 12'hee0, 12'ha2c, 12'h777};
   logic clk = 0, reset = 1, scale = 0;
   logic [10:0] x = 2000, y = 2000, x0 = 100, y0 = 50;
   logic [1:0] mode = 0;
   logic [5:0] period = 0;
   logic [11:0] sprite_rgb;
   logic [2:0] ani_id;
   int total = 0, bad = 0;
   int m_c = 0, m_ani = 0, m_scr = 0, m_xp = 0;
   logic [11:0] m_out = KEY, m_mid = KEY;

   always #5 clk = ~clk;

   banner_src #(.KEY_COLOR(KEY), .BG_COLOR(BG)) dut (
      .clk(clk), .reset(reset), .x(x), .y(y), .x0(x0), .y0(y0),
      .mode(mode), .period(period), .scale(scale),
      .sprite_rgb(sprite_rgb), .ani_id(ani_id)
   );

   task automatic chk(input string n, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
      end
   endtask

   function automatic logic [11:0] model_pix();
      int s = scale ? 2 : 1;
      int xr = int'(x) - int'(x0);
      int yr = int'(y) - int'(y0);
      int col, row;
      if (xr < 0 || yr < 0 || xr >= H * s || yr >= V * s) return KEY;
      if (mode == 2 && m_ani % 2 == 1) return KEY;
      col = (xr / s + m_scr) % H;
      row = yr / s;
      if (col % 8 == 0 || row % 8 == 3) return BG;
      return (mode == 1 || mode == 3) ? PAL[m_ani] : PAL[0];
   endfunction

   initial forever begin
      @(negedge clk);
      if (reset) begin
         m_c = 0; m_ani = 0; m_scr = 0; m_xp = 0; m_out = KEY; m_mid = KEY;
      end else begin
         bit ft;
         chk("model_rgb", sprite_rgb, m_out);
         chk("model_ani", ani_id, m_ani);
         m_out = m_mid;
         m_mid = model_pix();
         ft = m_xp == 0 && x == 1 && y == 0;
         if (ft) begin
            if (m_c == 0) m_ani = (m_ani + 1) % 8;
            m_c = (m_c >= int'(period)) ? 0 : m_c + 1;
         end
         m_scr = (mode != 3) ? 0 : ft ? (m_scr + 1) % H : m_scr;
         m_xp = x;
      end
   end

   task automatic drive(input int xv, input int yv);
      x = 11'(xv);
      y = 11'(yv);
      @(posedge clk);
      #2;
   endtask

   task automatic frame();
      drive(0, 0);
      drive(1, 0);
      drive(2000, 2000);
   endtask

   task automatic probe(input int xv, input int yv);
      drive(xv, yv);
      drive(2000, 2000);
   endtask

   initial begin
      #2;
      repeat (3) drive(2000, 2000);
      reset = 0;
      mode = 1; period = 0;
      repeat (3) frame();
      chk("ani_after3", ani_id, 3);
      probe(105, 50);
      chk("fg_ani3", sprite_rgb, 12'h00b);
      drive(105, 50);
      reset = 1;
      #1;
      chk("reset_rgb", sprite_rgb, KEY);
      chk("reset_ani", ani_id, 0);
      drive(2000, 2000);
      reset = 0;
      mode = 0;
      probe(105, 50);
      chk("refill_f00", sprite_rgb, 12'hf00);
      mode = 1; period = 2;
      repeat (21) frame();
      chk("cycle_ani7", ani_id, 7);
      frame();
      chk("cycle_wrap", ani_id, 0);
      mode = 2; period = 0;
      frame(); probe(105, 50);
      chk("blink_on0", sprite_rgb, 12'hf00);
      frame(); probe(105, 50);
      chk("blink_off", sprite_rgb, KEY);
      frame(); probe(105, 50);
      chk("blink_on2", sprite_rgb, 12'hf00);
      mode = 0; scale = 1;
      probe(100, 50);  chk("x2_origin", sprite_rgb, BG);
      probe(1123, 177); chk("x2_corner", sprite_rgb, 12'hf00);
      probe(1124, 177); chk("x2_right", sprite_rgb, KEY);
      probe(103, 53);  chk("x2_addr11", sprite_rgb, 12'hf00);
      probe(99, 50);   chk("x2_left", sprite_rgb, KEY);
      probe(100, 178); chk("x2_below", sprite_rgb, KEY);
      scale = 0; mode = 3;
      repeat (5) frame();
      probe(100, 50);
      chk("scroll5", sprite_rgb, 12'h777);
      repeat (507) frame();
      probe(100, 50);
      chk("scroll_wrap", sprite_rgb, BG);
      chk("scroll_ani", ani_id, 2);
      frame();
      probe(100, 50);
      chk("scroll1", sprite_rgb, 12'h00b);
      mode = 1;
      drive(2000, 2000);
      probe(100, 50);
      chk("scroll_clear", sprite_rgb, BG);
      period = 40;
      repeat (20) frame();
      chk("p40_ani", ani_id, 4);
      period = 3;
      frame();
      chk("p3_nostep", ani_id, 4);
      frame();
      chk("p3_step", ani_id, 5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
